// File: rtl/io_interrupt_ctrl.sv
// I/O flag and interrupt sequencer: INPR/OUTR latches, FGI/FGO, IEN, R and the RT0..RT2 interrupt cycle.
// Define IO_OVERRUN_DET_EN to enable the sticky overrun error flag on err (tied low otherwise).
module io_interrupt_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inp_valid,
  input  logic [DATA_W-1:0] inp_data,
  output logic              inp_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              inp_cmd,
  input  logic              out_cmd,
  input  logic [DATA_W-1:0] ac_in,
  output logic [DATA_W-1:0] inpr_q,
  input  logic              ion_cmd,
  input  logic              iof_cmd,
  input  logic              instr_done,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  output logic              int_active,
  output logic [2:0]        rt,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RT0  = 2'd1,
    RT1  = 2'd2,
    RT2  = 2'd3
  } state_e;

  state_e            state_q;
  logic              fgi_q, fgi_d;
  logic              fgo_q, fgo_d;
  logic              ovld_q, ovld_d;
  logic              ien_q;
  logic              r_q;
  logic [2:0]        rt_q;
  logic [DATA_W-1:0] inpr_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              inp_accept_s;
  logic              out_done_s;
  logic              out_take_s;

  assign inp_accept_s = inp_valid & ~fgi_q;
  assign out_done_s   = ovld_q & out_ready;
  // An out_cmd only loads OUTR when FGO was set; otherwise the word is dropped.
  assign out_take_s   = out_cmd & fgo_q;

  // Next-state for the device flags and data latches.
  always_comb begin
    fgi_d  = fgi_q;
    fgo_d  = fgo_q;
    ovld_d = ovld_q;
    inpr_d = inpr_q;
    outr_d = outr_q;
    if (inp_accept_s) begin
      fgi_d  = 1'b1;
      inpr_d = inp_data;
    end else if (inp_cmd) begin
      fgi_d  = 1'b0;
    end else begin
      fgi_d  = fgi_q;
    end
    if (out_take_s) begin
      outr_d = ac_in;
      fgo_d  = 1'b0;
      ovld_d = 1'b1;
    end else if (out_done_s) begin
      fgo_d  = 1'b1;
      ovld_d = 1'b0;
    end else begin
      fgo_d  = fgo_q;
      ovld_d = ovld_q;
    end
  end

  // Flag and latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fgi_q  <= 1'b0;
      fgo_q  <= 1'b1;
      ovld_q <= 1'b0;
      inpr_q <= '0;
      outr_q <= '0;
    end else begin
      fgi_q  <= fgi_d;
      fgo_q  <= fgo_d;
      ovld_q <= ovld_d;
      inpr_q <= inpr_d;
      outr_q <= outr_d;
    end
  end

  // Interrupt sequencer; IEN is only writable by ION/IOF while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rt_q    <= 3'b000;
      r_q     <= 1'b0;
      ien_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iof_cmd) begin
            ien_q <= 1'b0;
          end else if (ion_cmd) begin
            ien_q <= 1'b1;
          end else begin
            ien_q <= ien_q;
          end
          if (instr_done && ien_q && (fgi_q || fgo_q)) begin
            state_q <= RT0;
            rt_q    <= 3'b001;
            r_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            rt_q    <= 3'b000;
            r_q     <= 1'b0;
          end
        end
        RT0: begin
          state_q <= RT1;
          rt_q    <= 3'b010;
        end
        RT1: begin
          state_q <= RT2;
          rt_q    <= 3'b100;
        end
        RT2: begin
          state_q <= IDLE;
          rt_q    <= 3'b000;
          r_q     <= 1'b0;
          ien_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          rt_q    <= 3'b000;
          r_q     <= 1'b0;
          ien_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IO_OVERRUN_DET_EN
  logic err_q;

  // Sticky overrun: OUT while the device is busy, or INP with no fresh word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((out_cmd && !fgo_q) || (inp_cmd && !fgi_q)) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign inp_ready  = ~fgi_q;
  assign fgi        = fgi_q;
  assign fgo        = fgo_q;
  assign out_valid  = ovld_q;
  assign out_data   = outr_q;
  assign ien        = ien_q;
  assign int_active = r_q;
  assign rt         = rt_q;

endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// Bench for io_interrupt_ctrl: directed steps followed by random traffic, checked against a flag-level model.
module tb_io_interrupt_ctrl;

  logic        clk;
  logic        reset;
  logic        inp_valid;
  logic [15:0] inp_data;
  logic        inp_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        inp_cmd;
  logic        out_cmd;
  logic [15:0] ac_in;
  logic [15:0] inpr_q;
  logic        ion_cmd;
  logic        iof_cmd;
  logic        instr_done;
  logic        fgi;
  logic        fgo;
  logic        ien;
  logic        int_active;
  logic [2:0]  rt;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Model state: step 0 = no interrupt, 1..3 = RT0..RT2.
  logic        m_fgi, m_fgo, m_ov, m_ien, m_err;
  logic [15:0] m_inpr, m_outr;
  int          m_step;

  io_interrupt_ctrl #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .inp_valid(inp_valid), .inp_data(inp_data), .inp_ready(inp_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .inp_cmd(inp_cmd), .out_cmd(out_cmd), .ac_in(ac_in), .inpr_q(inpr_q),
    .ion_cmd(ion_cmd), .iof_cmd(iof_cmd), .instr_done(instr_done),
    .fgi(fgi), .fgo(fgo), .ien(ien), .int_active(int_active), .rt(rt), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fgi = 1'b0; m_fgo = 1'b1; m_ov = 1'b0; m_ien = 1'b0; m_err = 1'b0;
    m_inpr = 16'h0000; m_outr = 16'h0000; m_step = 0;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] exp_rt;
    exp_rt = (m_step == 0) ? 3'b000 : (3'b001 << (m_step - 1));
    chk({tag, ".fgi"}, fgi, m_fgi);
    chk({tag, ".inp_ready"}, inp_ready, !m_fgi);
    chk({tag, ".fgo"}, fgo, m_fgo);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".out_data"}, out_data, m_outr);
    chk({tag, ".inpr"}, inpr_q, m_inpr);
    chk({tag, ".ien"}, ien, m_ien);
    chk({tag, ".rt"}, rt, exp_rt);
    chk({tag, ".int_active"}, int_active, m_step != 0);
    chk({tag, ".err"}, err, m_err);
  endtask

  // Advance one clock: predict from the current inputs, clock, then compare.
  task automatic cycle(input string tag);
    logic        n_fgi, n_fgo, n_ov, n_ien, n_err;
    logic [15:0] n_inpr, n_outr;
    int          n_step;
    n_fgi = m_fgi; n_fgo = m_fgo; n_ov = m_ov; n_ien = m_ien; n_err = m_err;
    n_inpr = m_inpr; n_outr = m_outr; n_step = m_step;
    if (inp_valid && !m_fgi) begin
      n_fgi = 1'b1;
      n_inpr = inp_data;
    end else if (inp_cmd) begin
      n_fgi = 1'b0;
    end
    if (out_cmd && m_fgo) begin
      n_outr = ac_in; n_fgo = 1'b0; n_ov = 1'b1;
    end else if (m_ov && out_ready) begin
      n_ov = 1'b0; n_fgo = 1'b1;
    end
`ifdef IO_OVERRUN_DET_EN
    if ((out_cmd && !m_fgo) || (inp_cmd && !m_fgi)) n_err = 1'b1;
`endif
    if (m_step == 0) begin
      if (iof_cmd) n_ien = 1'b0;
      else if (ion_cmd) n_ien = 1'b1;
      if (instr_done && m_ien && (m_fgi || m_fgo)) n_step = 1;
    end else if (m_step == 3) begin
      n_step = 0;
      n_ien = 1'b0;
    end else begin
      n_step = m_step + 1;
    end
    @(posedge clk);
    #1;
    m_fgi = n_fgi; m_fgo = n_fgo; m_ov = n_ov; m_ien = n_ien; m_err = n_err;
    m_inpr = n_inpr; m_outr = n_outr; m_step = n_step;
    inp_valid = 1'b0; inp_cmd = 1'b0; out_cmd = 1'b0;
    ion_cmd = 1'b0; iof_cmd = 1'b0; instr_done = 1'b0;
    check_all(tag);
  endtask

  logic exp_err;

  initial begin
    reset = 1'b1; inp_valid = 1'b0; inp_data = 16'h0000; out_ready = 1'b0;
    inp_cmd = 1'b0; out_cmd = 1'b0; ac_in = 16'h0000;
    ion_cmd = 1'b0; iof_cmd = 1'b0; instr_done = 1'b0;
    model_reset();
`ifdef IO_OVERRUN_DET_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #12;
    check_all("reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle("idle");
    chk("idle_fgo_const", fgo, 1'b1);

    // Input word then INP two cycles later.
    inp_valid = 1'b1; inp_data = 16'h00A5;
    cycle("inp_accept");
    chk("inpr_a5", inpr_q, 16'h00A5);
    chk("fgi_set", fgi, 1'b1);
    cycle("inp_wait");
    inp_cmd = 1'b1;
    cycle("inp_cmd");
    chk("fgi_clr", fgi, 1'b0);
    chk("inpr_kept", inpr_q, 16'h00A5);

    // OUT with the device stalling four cycles.
    out_cmd = 1'b1; ac_in = 16'h1234;
    cycle("out_cmd");
    for (int i = 0; i < 4; i++) begin
      chk("out_valid_held", out_valid, 1'b1);
      cycle("out_stall");
    end
    chk("out_data_1234", out_data, 16'h1234);
    out_ready = 1'b1;
    cycle("out_hs");
    chk("fgo_after_hs", fgo, 1'b1);
    out_ready = 1'b0;

    // ION, input word, instr_done -> full interrupt cycle, no re-entry.
    ion_cmd = 1'b1;
    cycle("ion");
    inp_valid = 1'b1; inp_data = 16'h0F0F;
    cycle("inp_word");
    instr_done = 1'b1;
    cycle("int_entry");
    chk("rt0", rt, 3'b001);
    instr_done = 1'b1;
    cycle("rt1");
    chk("rt1", rt, 3'b010);
    ion_cmd = 1'b1;
    cycle("rt2");
    chk("rt2", rt, 3'b100);
    cycle("int_exit");
    chk("ien_cleared", ien, 1'b0);
    instr_done = 1'b1;
    cycle("no_reentry");
    chk("no_reentry_rt", rt, 3'b000);

    // ION and IOF together: IOF wins.
    ion_cmd = 1'b1; iof_cmd = 1'b1;
    cycle("ion_iof");
    chk("iof_wins", ien, 1'b0);

    // Reset asserted during RT1 takes effect immediately.
    ion_cmd = 1'b1;
    cycle("ion2");
    instr_done = 1'b1;
    cycle("int2_rt0");
    cycle("int2_rt1");
    chk("in_rt1", rt, 3'b010);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    #2 reset = 1'b0;
    cycle("post_reset");

    // Overrun: second OUT while FGO=0, then OUT coinciding with the handshake.
    out_cmd = 1'b1; ac_in = 16'hBEEF;
    cycle("ovr_first");
    out_cmd = 1'b1; ac_in = 16'h5555;
    cycle("ovr_second");
    chk("ovr_outr_kept", out_data, 16'hBEEF);
    chk("ovr_err", err, exp_err);
    out_cmd = 1'b1; ac_in = 16'h7777; out_ready = 1'b1;
    cycle("ovr_same_cycle");
    chk("ovr_same_outr", out_data, 16'hBEEF);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("err_sticky");
    chk("err_sticky", err, exp_err);
    reset = 1'b1;
    #1;
    model_reset();
    check_all("err_reset");
    #2 reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      inp_valid  = ($urandom_range(0, 1) == 0);
      inp_data   = 16'($urandom);
      out_ready  = ($urandom_range(0, 2) == 0);
      inp_cmd    = ($urandom_range(0, 3) == 0);
      out_cmd    = ($urandom_range(0, 3) == 0);
      ac_in      = 16'($urandom);
      ion_cmd    = ($urandom_range(0, 3) == 0);
      iof_cmd    = ($urandom_range(0, 7) == 0);
      instr_done = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
